// File: rtl/issue_unit_pkg.sv
// Shared types for the issue stage: FU classes, the RS instruction payload and the RS entry wrapper.
package issue_unit_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 6;
    localparam int FU_IDX_W    = 2;

    // Three bits so that out-of-range selectors from a corrupted entry stay representable.
    typedef enum logic [2:0] {
        FU_ALU  = 3'd0,
        FU_BTU  = 3'd1,
        FU_MULT = 3'd2,
        FU_LSU  = 3'd3
    } fu_sel_e;

    typedef struct packed {
        logic [ROB_TAG_LEN-1:0] insn_tag;
        fu_sel_e                fu_sel;
        logic [6:0]             opcode;
        logic [XLEN-1:0]        rs1_value;
        logic [XLEN-1:0]        rs2_value;
    } inst_rs_t;

    typedef struct packed {
        logic     valid;
        inst_rs_t insn;
    } rs_entry_t;

    function automatic logic fu_sel_valid(input fu_sel_e sel);
        return sel inside {FU_ALU, FU_BTU, FU_MULT, FU_LSU};
    endfunction

endpackage

// File: rtl/issue_unit_slot.sv
// One per-FU issue register: loads an accepted instruction, empties when the FU consumes it or on flush.
module issue_slot
    import issue_unit_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     load,
    input  logic     consume,
    input  inst_rs_t insn_in,
    output logic     valid,
    output inst_rs_t insn
);

    logic     valid_d, valid_q;
    inst_rs_t insn_d, insn_q;

    always_comb begin
        valid_d = valid_q;
        insn_d  = insn_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            insn_d  = insn_in;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            insn_q  <= '0;
        end else begin
            valid_q <= valid_d;
            insn_q  <= insn_d;
        end
    end

    assign valid = valid_q;
    assign insn  = insn_q;

endmodule

// File: rtl/issue_unit.sv
// Takes the RS oldest-ready entry, drops one-cycle stale re-presentations and routes it into a per-FU issue register.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int NUM_FU    = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  rs_entry_t              insn_for_ex,
    input  logic                   flush,
    input  logic [NUM_FU-1:0]      fu_ready,
    output logic                   clear,
    output logic [ROB_TAG_LEN-1:0] clear_tag,
    output logic [NUM_FU-1:0]      fu_issue_valid,
    output inst_rs_t               fu_issue_insn [NUM_FU],
    output logic [CNT_WIDTH-1:0]   issue_count,
    output logic [CNT_WIDTH-1:0]   stall_count
);

    logic [ROB_TAG_LEN-1:0] last_tag_d, last_tag_q;
    logic                   last_tag_valid_d, last_tag_valid_q;
    logic [CNT_WIDTH-1:0]   issue_count_d, issue_count_q;
    logic [CNT_WIDTH-1:0]   stall_count_d, stall_count_q;

    logic [NUM_FU-1:0]      slot_free;
    logic [2:0]             sel_idx;
    logic                   sel_free;
    logic                   dup;
    logic                   live;
    logic                   accept;
    logic                   stall;

    // NOTE: every signal in this block gets a default first, so no path can infer a latch.
    always_comb begin
        sel_idx          = insn_for_ex.insn.fu_sel;
        slot_free        = ~fu_issue_valid | fu_ready;
        sel_free         = fu_sel_valid(insn_for_ex.insn.fu_sel) && slot_free[sel_idx[FU_IDX_W-1:0]];
        dup              = last_tag_valid_q && (insn_for_ex.insn.insn_tag == last_tag_q);
        live             = reset && !flush && insn_for_ex.valid && !dup;
        accept           = live && sel_free;
        stall            = live && !sel_free;

        clear            = accept;
        clear_tag        = accept ? insn_for_ex.insn.insn_tag : '0;

        // The RS shows a freed entry for one more cycle, so the filter only remembers the last accept.
        last_tag_valid_d = accept;
        last_tag_d       = accept ? insn_for_ex.insn.insn_tag : last_tag_q;

        issue_count_d    = issue_count_q + (accept ? CNT_WIDTH'(1) : '0);
        stall_count_d    = stall_count_q + (stall  ? CNT_WIDTH'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_tag_q       <= '0;
            last_tag_valid_q <= 1'b0;
            issue_count_q    <= '0;
            stall_count_q    <= '0;
        end else begin
            last_tag_q       <= last_tag_d;
            last_tag_valid_q <= last_tag_valid_d;
            issue_count_q    <= issue_count_d;
            stall_count_q    <= stall_count_d;
        end
    end

    for (genvar k = 0; k < NUM_FU; k++) begin : g_slot
        issue_slot u_slot (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .load    (accept && (sel_idx == 3'(k))),
            .consume (fu_ready[k]),
            .insn_in (insn_for_ex.insn),
            .valid   (fu_issue_valid[k]),
            .insn    (fu_issue_insn[k])
        );
    end

    assign issue_count = issue_count_q;
    assign stall_count = stall_count_q;

    a_fu_sel_known: assert property (@(posedge clk) disable iff (!reset)
        (insn_for_ex.valid && !flush) |-> fu_sel_valid(insn_for_ex.insn.fu_sel));

endmodule
